// File: rtl/user_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : user_input_conditioner
//  Description : Button front end for the control FSM. Each raw button line
//                is synchronized with two flops and debounced with a per-bit
//                counter. A debounced rising edge becomes a one-cycle press
//                pulse, gated by enable. A saturating 8-bit counter tallies
//                the accepted press events.
//  Revision    : 1.0  initial release
// ============================================================================
module user_input_conditioner #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_raw,
  input  logic             enable,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic             event_valid,
  output logic [7:0]       press_count
);

  // The level flips on the edge at which a disagreeing input has already
  // been counted DEBOUNCE_CYCLES-1 times.
  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [7:0]       c_count_max = 8'hFF;
  localparam logic [7:0]       c_count_one = 8'h01;

  logic [WIDTH-1:0]            r_sync1;
  logic [WIDTH-1:0]            r_sync2;
  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]            r_level;
  logic [WIDTH-1:0]            r_level_d;
  logic [WIDTH-1:0]            r_pulse;
  logic                        r_event;
  logic [7:0]                  r_count;
  logic [WIDTH-1:0]            w_rise;

  // Two-flop synchronizer; only r_sync2 is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-bit debounce: count consecutive disagreeing cycles; any agreement
  // restarts the count, so short glitches never reach the level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_cnt_last) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + c_cnt_one;
        end
      end
    end
  end

  assign w_rise = r_level & ~r_level_d;

  // Rising-edge detect on the debounced level; enable is sampled on the same
  // edge, so a press seen while disabled is dropped rather than deferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level_d <= '0;
      r_pulse   <= '0;
      r_event   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_pulse   <= enable ? w_rise : '0;
      r_event   <= enable & (|w_rise);
    end
  end

  // Saturating tally of cycles with a registered event; lags event_valid by one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_event && (r_count != c_count_max)) begin
      r_count <= r_count + c_count_one;
    end
  end

  assign btn_level   = r_level;
  assign press_pulse = r_pulse;
  assign event_valid = r_event;
  assign press_count = r_count;

endmodule
`default_nettype wire
